pad_cursor_mover: RTL and testbench
===================================

Name: pad_cursor_mover

Overview:
- Consumes the four decoded direction buttons and the Readable qualifier from the NES/SNES controller reader.
- Converts them into a clamped sprite/cursor position (Pos_X, Pos_Y) that the VGA renderer draws.
- Movement happens only on frame ticks from the VGA timing block, with an initial move, a hold delay, then auto-repeat.
- Also reports controller link health.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 16, sprite width; X_MAX = SCREEN_W-SPRITE_W
- SPRITE_H, 16, sprite height; Y_MAX = SCREEN_H-SPRITE_H
- STEP, 2, pixels moved per move event (1..15)
- START_X, 312, reset X position
- START_Y, 232, reset Y position
- REPEAT_DELAY, 15, frame ticks from first move to first repeat (>=1)
- REPEAT_RATE, 2, frame ticks between repeats (>=1)
- TIMEOUT_CYCLES, 1000000, clock cycles without a Readable rise before the link is declared lost

Ports:
- Clock  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Up  in  1  reader output, active high
- Down  in  1  reader output, active high
- Left  in  1  reader output, active high
- Right  in  1  reader output, active high
- Readable  in  1  high while button outputs are valid; rises once per controller scan
- Frame_Tick  in  1  one-cycle pulse per frame (start of vblank)
- Pos_X  out  10  cursor X, 0..X_MAX
- Pos_Y  out  10  cursor Y, 0..Y_MAX
- Moved  out  1  one-cycle pulse when Pos_X or Pos_Y changed
- Link_OK  out  1  high while scans arrive within TIMEOUT_CYCLES

Behaviour:
- Reset (async, Reset_n=0):
  - Pos_X=START_X, Pos_Y=START_Y, Moved=0, Link_OK=0.
  - Latched buttons=0, FSM=IDLE, repeat counter=0, timeout counter=0, Readable_d=0.
- Capture:
  - Readable_d registers Readable.
  - Scan edge = Readable & ~Readable_d.
  - On a scan edge: latch Up/Down/Left/Right, set Link_OK=1, clear the timeout counter.
  - Buttons are never sampled outside a scan edge.
- Timeout:
  - The counter increments each cycle without a scan edge and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: Link_OK=0 and latched buttons cleared (treated as released).
- Direction:
  - dx = +1 if R&~L, -1 if L&~R, else 0.
  - dy = +1 if D&~U, -1 if U&~D, else 0 (Y grows downward).
  - Opposing presses cancel on that axis only.
  - active = (dx!=0)|(dy!=0).
- FSM (all transitions only on Frame_Tick; counter cnt):
  - IDLE: if active -> move, cnt=REPEAT_DELAY-1, go DELAY.
  - DELAY: if !active -> IDLE, no move. Else if cnt==0 -> move, cnt=REPEAT_RATE-1, go REPEAT. Else cnt--.
  - REPEAT: if !active -> IDLE. Else if cnt==0 -> move, cnt=REPEAT_RATE-1. Else cnt--.
  - A direction change while held does not restart the FSM.
- Move/clamp, per axis, computed in 11 bits:
  - +: new = min(pos+STEP, MAX).
  - -: new = (pos>=STEP) ? pos-STEP : 0.
  - 0: unchanged.
- Latency: new Pos and the Moved pulse appear on the cycle after the Frame_Tick cycle.
  - Moved=1 only if at least one coordinate actually changed; pressing into an edge gives Moved=0.
- Simultaneous Frame_Tick and scan edge: the move uses the previously latched buttons; new buttons take effect from the next tick.
- Frame_Tick held high for multiple cycles counts once per cycle; the upstream block guarantees single-cycle pulses.
- Reset mid-hold: returns to IDLE at the start position; no residual repeat.

Decomposition:
- Package vga_input_pkg:
  - typedef enum logic[1:0] move_state_t {IDLE, DELAY, REPEAT}.
  - Typedef pos_t = logic[9:0].
  - Default screen and sprite constants.
- Sub-module axis_stepper (instantiated twice):
  - Inputs: pos, dir (-1/0/+1), max, step, enable.
  - Outputs: the clamped next position and a changed flag.

Test Plan:
- Reset, then a scan edge with Right=1 and 18 Frame_Ticks -> X goes 312->314 at tick 1, 316 at tick 16, 318 at tick 18; Y stays 232; Moved pulses exactly 3 times.
- Start X=4, hold Left for 40 ticks -> X goes 2, 0, then stays 0; Moved=0 once X is clamped.
- Hold Down from Y=462 -> Y=464 (Y_MAX) and stays there.
- Latch Left=1 and Right=1 together, then 20 ticks -> X unchanged, FSM stays IDLE, Moved never pulses.
- Hold Up for 5 ticks, release (scan edge with Up=0), press again -> an immediate move on the next tick (FSM was back in IDLE).
- After one scan edge, no further Readable rises for TIMEOUT_CYCLES (bench override 100) -> Link_OK falls at cycle 100 and movement stops; the next scan edge restores Link_OK=1.
- Assert Reset_n=0 mid-repeat -> Pos returns to (312,232) immediately; Moved=0 and Link_OK=0.

Source files
------------

// File: rtl/vga_input_pkg.sv
// Shared types and defaults for the pad-driven cursor path.
// Screen/sprite geometry plus axis direction helpers.
package vga_input_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } move_state_t;

   typedef logic [9:0] pos_t;

   // -1 / 0 / +1 along one axis
   typedef logic signed [1:0] dir_t;

   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;
   localparam int DEF_SPRITE_W = 16;
   localparam int DEF_SPRITE_H = 16;

   // Opposing presses cancel on their own axis.
   function automatic dir_t axis_dir(
      input logic plus,
      input logic minus
   );
      if (plus && !minus)
         return 2'sd1;
      else if (minus && !plus)
         return -2'sd1;
      else
         return 2'sd0;
   endfunction

endpackage

// File: rtl/axis_stepper.sv
// One-axis clamped stepper: moves pos by step toward dir,
// clamped to [0, max_pos]; reports whether the value changed.
module axis_stepper
   import vga_input_pkg::*;
(
   input  pos_t       pos,
   input  dir_t       dir,
   input  pos_t       max_pos,
   input  logic [3:0] step,
   input  logic       enable,
   output pos_t       nxt,
   output logic       changed
);

   logic [10:0] sum;

   // Next position; the 11-bit sum keeps pos+step from wrapping.
   always_comb begin
      sum = {1'b0, pos} + {7'd0, step};
      nxt = pos;
      if (enable) begin
         if (dir == 2'sd1) begin
            if (sum > {1'b0, max_pos})
               nxt = max_pos;
            else
               nxt = sum[9:0];
         end else if (dir == -2'sd1) begin
            if (pos >= pos_t'(step))
               nxt = pos - pos_t'(step);
            else
               nxt = '0;
         end
      end
      changed = (nxt != pos);
   end

endmodule

// File: rtl/pad_cursor_mover.sv
// Turns latched pad buttons into a clamped cursor position,
// moving on frame ticks with initial move, hold delay, repeat.
module pad_cursor_mover
   import vga_input_pkg::*;
#(
   parameter int SCREEN_W       = DEF_SCREEN_W,
   parameter int SCREEN_H       = DEF_SCREEN_H,
   parameter int SPRITE_W       = DEF_SPRITE_W,
   parameter int SPRITE_H       = DEF_SPRITE_H,
   parameter int STEP           = 2,
   parameter int START_X        = 312,
   parameter int START_Y        = 232,
   parameter int REPEAT_DELAY   = 15,
   parameter int REPEAT_RATE    = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic Up,
   input  logic Down,
   input  logic Left,
   input  logic Right,
   input  logic Readable,
   input  logic Frame_Tick,
   output pos_t Pos_X,
   output pos_t Pos_Y,
   output logic Moved,
   output logic Link_OK
);

   localparam pos_t X_MAX = pos_t'(SCREEN_W - SPRITE_W);
   localparam pos_t Y_MAX = pos_t'(SCREEN_H - SPRITE_H);
   localparam int   RMAX  = (REPEAT_DELAY > REPEAT_RATE) ?
                            REPEAT_DELAY : REPEAT_RATE;
   localparam int   CW    = $clog2(RMAX + 1);
   localparam int   TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] CNT_DELAY = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] CNT_RATE  = CW'(REPEAT_RATE - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_SAT     = TW'(TIMEOUT_CYCLES);

   logic          readable_d;
   logic          scan;
   logic [3:0]    btn;
   logic [TW-1:0] tcnt;

   move_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          do_move;

   dir_t          dx, dy;
   logic          active;
   pos_t          nx, ny;
   logic          cx, cy;

   assign scan   = Readable & ~readable_d;
   assign dx     = axis_dir(btn[0], btn[1]);
   assign dy     = axis_dir(btn[2], btn[3]);
   assign active = (dx != 2'sd0) | (dy != 2'sd0);

   // Button latch on scan edges; link watchdog releases buttons.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         readable_d <= 1'b0;
         btn        <= '0;
         tcnt       <= '0;
         Link_OK    <= 1'b0;
      end else begin
         readable_d <= Readable;
         if (scan) begin
            btn     <= {Up, Down, Left, Right};
            tcnt    <= '0;
            Link_OK <= 1'b1;
         end else if (tcnt == T_LAST) begin
            tcnt    <= T_SAT;
            btn     <= '0;
            Link_OK <= 1'b0;
         end else if (tcnt != T_SAT) begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   // Hold FSM state and repeat counter.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Tick-driven move scheduling: first move, delay, repeat.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      do_move   = 1'b0;
      if (Frame_Tick) begin
         unique case (state)
            IDLE: begin
               if (active) begin
                  do_move   = 1'b1;
                  cnt_nxt   = CNT_DELAY;
                  state_nxt = DELAY;
               end
            end
            DELAY, REPEAT: begin
               if (!active) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else if (cnt == '0) begin
                  do_move   = 1'b1;
                  cnt_nxt   = CNT_RATE;
                  state_nxt = REPEAT;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   axis_stepper u_step_x (
      .pos     (Pos_X),
      .dir     (dx),
      .max_pos (X_MAX),
      .step    (4'(STEP)),
      .enable  (do_move),
      .nxt     (nx),
      .changed (cx)
   );

   axis_stepper u_step_y (
      .pos     (Pos_Y),
      .dir     (dy),
      .max_pos (Y_MAX),
      .step    (4'(STEP)),
      .enable  (do_move),
      .nxt     (ny),
      .changed (cy)
   );

   // Position register; Moved flags a real coordinate change.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Pos_X <= pos_t'(START_X);
         Pos_Y <= pos_t'(START_Y);
         Moved <= 1'b0;
      end else begin
         Pos_X <= nx;
         Pos_Y <= ny;
         Moved <= cx | cy;
      end
   end

endmodule

// File: tb/tb_pad_cursor_mover.sv
// Randomized scoreboard bench for pad_cursor_mover against
// a tick-counting reference model of the hold/repeat rules.
module tb_pad_cursor_mover;

   localparam int TO    = 100;
   localparam int STEP  = 2;
   localparam int X_MAX = 624;
   localparam int Y_MAX = 464;
   localparam int SX    = 312;
   localparam int SY    = 232;
   localparam int RD    = 15;
   localparam int RR    = 2;

   logic       Clock = 1'b0;
   logic       Reset_n;
   logic       Up, Down, Left, Right;
   logic       Readable, Frame_Tick;
   logic [9:0] Pos_X, Pos_Y;
   logic       Moved, Link_OK;

   pad_cursor_mover #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Up         (Up),
      .Down       (Down),
      .Left       (Left),
      .Right      (Right),
      .Readable   (Readable),
      .Frame_Tick (Frame_Tick),
      .Pos_X      (Pos_X),
      .Pos_Y      (Pos_Y),
      .Moved      (Moved),
      .Link_OK    (Link_OK)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int x;
      int y;
      bit moved;
      bit link;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   moved_seen = 0;

   // reference model state
   int       mx, my, mt, mn;
   bit       mlink, mmoved, mrd;
   bit [3:0] mbtn;

   function automatic int sgn(input bit p, input bit m);
      if (p && !m) return 1;
      if (m && !p) return -1;
      return 0;
   endfunction

   function automatic int mv_axis(input int p, input int d, input int lim);
      if (d > 0) return (p + STEP > lim) ? lim : p + STEP;
      if (d < 0) return (p >= STEP) ? p - STEP : 0;
      return p;
   endfunction

   task automatic model_reset();
      mx = SX; my = SY; mt = 0; mn = 0;
      mlink = 0; mmoved = 0; mrd = 0; mbtn = '0;
   endtask

   // mn = number of consecutive ticks the pad has been held
   task automatic model_step(input bit [3:0] b, input bit rd, input bit tk);
      int  dx, dy, nx, ny;
      bit  act, go, scan;
      scan = rd && !mrd;
      dx = sgn(mbtn[0], mbtn[1]);
      dy = sgn(mbtn[2], mbtn[3]);
      act = (dx != 0) || (dy != 0);
      go = 0;
      if (tk) begin
         if (!act) mn = 0;
         else begin
            mn++;
            go = (mn == 1) || (mn > RD && ((mn - RD - 1) % RR) == 0);
         end
      end
      mmoved = 0;
      if (go) begin
         nx = mv_axis(mx, dx, X_MAX);
         ny = mv_axis(my, dy, Y_MAX);
         mmoved = (nx != mx) || (ny != my);
         mx = nx; my = ny;
      end
      if (scan) begin
         mbtn = b; mlink = 1; mt = 0;
      end else if (mt < TO) begin
         mt++;
         if (mt == TO) begin
            mlink = 0; mbtn = '0;
         end
      end
      mrd = rd;
   endtask

   task automatic drive(input bit [3:0] b, input bit rd, input bit tk,
                        input bit rn = 1'b1);
      exp_t e;
      @(negedge Clock);
      Reset_n = rn;
      {Up, Down, Left, Right} = b;
      Readable = rd;
      Frame_Tick = tk;
      if (!rn) model_reset();
      else model_step(b, rd, tk);
      e.x = mx; e.y = my; e.moved = mmoved; e.link = mlink;
      sbq.push_back(e);
   endtask

   // one controller scan plus one frame tick
   task automatic frame(input bit [3:0] b);
      drive(b, 1, 0);
      drive(b, 1, 0);
      drive(b, 0, 0);
      drive(b, 0, 1);
      repeat (4) drive(b, 0, 0);
   endtask

   task automatic check_now(input string nm, input int ex, input int ey,
                            input bit em, input bit el);
      vectors++;
      if (int'(Pos_X) != ex || int'(Pos_Y) != ey ||
          Moved != em || Link_OK != el) begin
         miscompares++;
         $display("FAIL %s: got x=%0d y=%0d moved=%0b link=%0b, want x=%0d y=%0d moved=%0b link=%0b",
                  nm, Pos_X, Pos_Y, Moved, Link_OK, ex, ey, em, el);
      end
   endtask

   task automatic check_cnt(input string nm, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   // scoreboard monitor: one expectation per clocked cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (int'(Pos_X) != e.x || int'(Pos_Y) != e.y ||
                Moved != e.moved || Link_OK != e.link) begin
               miscompares++;
               $display("FAIL sb @%0t: got x=%0d y=%0d moved=%0b link=%0b, want x=%0d y=%0d moved=%0b link=%0b",
                        $time, Pos_X, Pos_Y, Moved, Link_OK,
                        e.x, e.y, e.moved, e.link);
            end
         end
      end
   end

   always @(negedge Clock) if (Moved) moved_seen++;

   initial begin
      bit [3:0] hold;
      bit       rd;
      Reset_n = 0;
      {Up, Down, Left, Right} = '0;
      Readable = 0;
      Frame_Tick = 0;
      model_reset();

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      check_now("reset", SX, SY, 0, 0);
      drive(0, 0, 0, 1);

      moved_seen = 0;
      repeat (18) frame(4'b0001);
      check_now("right18", 318, SY, 0, 1);
      check_cnt("right18_pulses", moved_seen, 3);
      frame(0);

      repeat (340) frame(4'b0010);
      moved_seen = 0;
      repeat (20) frame(4'b0010);
      check_now("left_clamp", 0, SY, 0, 1);
      check_cnt("left_clamp_pulses", moved_seen, 0);
      frame(0);

      repeat (250) frame(4'b0100);
      moved_seen = 0;
      repeat (10) frame(4'b0100);
      check_now("down_clamp", 0, Y_MAX, 0, 1);
      check_cnt("down_clamp_pulses", moved_seen, 0);
      frame(0);

      moved_seen = 0;
      repeat (20) frame(4'b0011);
      check_now("lr_cancel", 0, Y_MAX, 0, 1);
      check_cnt("lr_cancel_pulses", moved_seen, 0);

      moved_seen = 0;
      repeat (5) frame(4'b1000);
      frame(0);
      frame(4'b1000);
      frame(0);
      check_now("up_repress", 0, Y_MAX - 4, 0, 1);
      check_cnt("up_repress_pulses", moved_seen, 2);

      moved_seen = 0;
      drive(4'b0001, 1, 0);
      for (int i = 0; i < 130; i++)
         drive(4'b0001, 0, (i % 8) == 3);
      check_now("timeout", 2, Y_MAX - 4, 0, 0);
      check_cnt("timeout_pulses", moved_seen, 1);
      frame(0);
      check_now("relink", 2, Y_MAX - 4, 0, 1);

      hold = 4'b0001;
      rd = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) hold = 4'($urandom);
         if (i >= 2000 && i < 2150) rd = 0;
         else if ($urandom_range(0, 3) == 0) rd = ~rd;
         drive(hold, rd, $urandom_range(0, 5) == 0);
      end

      frame(0);
      repeat (20) frame(4'b0100);
      drive(4'b0100, 0, 0, 0);
      #1;
      check_now("reset_mid", SX, SY, 0, 0);
      drive(4'b0100, 0, 0, 0);
      drive(0, 0, 0, 1);
      moved_seen = 0;
      frame(4'b1000);
      check_now("post_reset", SX, SY - 2, 0, 1);
      check_cnt("post_reset_pulses", moved_seen, 1);

      for (int i = 0; i < 10 && sbq.size() > 0; i++)
         @(posedge Clock);
      @(negedge Clock);
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
